full_vector_writer: RTL and testbench

//  Write-back counterpart of the vector-read path. Accepts whole result vectors over a valid/ready handshake.

---
 rtl/vector_pkg.sv | 22 ++
 rtl/vector_shift_buffer.sv | 69 ++++++
 rtl/full_vector_writer.sv | 138 +++++++++++++
 tb/tb_full_vector_writer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared state encoding, default widths and index sizing for the vector writer
package vector_pkg;

    localparam int DEF_ELEMENT_WIDTH    = 24;
    localparam int DEF_ADDR_WIDTH       = 17;
    localparam int DEF_VECTOR_DIMENSION = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } writer_state_t;

    // Element index width; a one-element vector still needs a 1-bit index
    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    typedef logic [idx_width(DEF_VECTOR_DIMENSION)-1:0] elem_idx_t;

endpackage

// File: rtl/vector_shift_buffer.sv
// rtl/vector_shift_buffer.sv - load-whole / emit-one-element register bank; pending slot when VECTOR_WRITER_SKID_EN is defined
module vector_shift_buffer
    import vector_pkg::*;
#(
    parameter int ELEMENT_WIDTH    = DEF_ELEMENT_WIDTH,
    parameter int VECTOR_DIMENSION = DEF_VECTOR_DIMENSION,
    parameter int IDX_W            = idx_width(DEF_VECTOR_DIMENSION)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_load,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [ELEMENT_WIDTH-1:0] i_vector [0:VECTOR_DIMENSION-1],
`ifdef VECTOR_WRITER_SKID_EN
    input  logic                     i_pend_load,
    input  logic                     i_promote,
    input  logic                     i_drop,
    output logic                     o_pend_full,
`endif
    output logic [ELEMENT_WIDTH-1:0] o_elem
);

    logic [ELEMENT_WIDTH-1:0] r_buf [0:VECTOR_DIMENSION-1];

`ifdef VECTOR_WRITER_SKID_EN
    logic [ELEMENT_WIDTH-1:0] r_pend [0:VECTOR_DIMENSION-1];
    logic                     r_pend_full;

    // Working vector: taken straight from the input, or promoted from the pending slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VECTOR_DIMENSION; i++) r_buf[i] <= '0;
        end else if (i_load) begin
            r_buf <= i_vector;
        end else if (i_promote) begin
            r_buf <= r_pend;
        end
    end

    // Pending slot: a drop at end of job wins over a same-cycle load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VECTOR_DIMENSION; i++) r_pend[i] <= '0;
            r_pend_full <= 1'b0;
        end else if (i_drop) begin
            r_pend_full <= 1'b0;
        end else if (i_pend_load) begin
            r_pend      <= i_vector;
            r_pend_full <= 1'b1;
        end else if (i_promote) begin
            r_pend_full <= 1'b0;
        end
    end

    assign o_pend_full = r_pend_full;
`else
    // Working vector: loaded whole on each accepted handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VECTOR_DIMENSION; i++) r_buf[i] <= '0;
        end else if (i_load) begin
            r_buf <= i_vector;
        end
    end
`endif

    assign o_elem = r_buf[i_idx];

endmodule

// File: rtl/full_vector_writer.sv
// rtl/full_vector_writer.sv - serialises result vectors into one memory write per cycle; VECTOR_WRITER_SKID_EN removes the per-vector bubble
module full_vector_writer
    import vector_pkg::*;
#(
    parameter int ELEMENT_WIDTH    = DEF_ELEMENT_WIDTH,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int VECTOR_DIMENSION = DEF_VECTOR_DIMENSION
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enabled,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [ADDR_WIDTH-1:0]    expected_elements,
    input  logic [ELEMENT_WIDTH-1:0] vector_in [0:VECTOR_DIMENSION-1],
    input  logic                     vector_valid,
    output logic                     vector_ready,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_data,
    output logic                     mem_we,
    output logic                     busy,
    output logic                     done
);

    localparam int               IDX_W    = idx_width(VECTOR_DIMENSION);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_DIMENSION - 1);

    writer_state_t            r_state;
    logic [ADDR_WIDTH-1:0]    r_ptr;
    logic [ADDR_WIDTH-1:0]    r_rem;
    logic [IDX_W-1:0]         r_idx;

    logic                     w_hs;
    logic                     w_writing;
    logic                     w_last_write;
    logic                     w_load;
    logic                     w_continue;
    logic [ELEMENT_WIDTH-1:0] w_elem;

    assign w_writing    = (r_state == WRITE) && enabled;
    assign w_last_write = (r_rem == ADDR_WIDTH'(1));

`ifdef VECTOR_WRITER_SKID_EN
    logic w_pend_full;
    logic w_vec_end;
    logic w_promote;
    logic w_bypass;
    logic w_pend_load;
    logic w_drop;

    // A vector boundary that still has writes left to issue
    assign w_vec_end    = w_writing && !w_last_write && (r_idx == LAST_IDX);
    assign vector_ready = enabled && !w_pend_full && ((r_state == ACCEPT) || (r_state == WRITE));
    assign w_hs         = vector_valid && vector_ready;
    assign w_promote    = w_vec_end && w_pend_full;
    // A vector arriving exactly at the boundary goes straight to the working buffer
    assign w_bypass     = w_vec_end && !w_pend_full && w_hs;
    assign w_load       = (w_hs && (r_state == ACCEPT)) || w_bypass;
    assign w_pend_load  = w_hs && (r_state == WRITE) && !w_bypass;
    assign w_drop       = (w_writing && w_last_write) || (r_state == DONE);
    assign w_continue   = w_promote || w_bypass;
`else
    assign vector_ready = enabled && (r_state == ACCEPT);
    assign w_hs         = vector_valid && vector_ready;
    assign w_load       = w_hs;
    assign w_continue   = 1'b0;
`endif

    vector_shift_buffer #(
        .ELEMENT_WIDTH    (ELEMENT_WIDTH),
        .VECTOR_DIMENSION (VECTOR_DIMENSION),
        .IDX_W            (IDX_W)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_idx       (r_idx),
        .i_vector    (vector_in),
`ifdef VECTOR_WRITER_SKID_EN
        .i_pend_load (w_pend_load),
        .i_promote   (w_promote),
        .i_drop      (w_drop),
        .o_pend_full (w_pend_full),
`endif
        .o_elem      (w_elem)
    );

    // Job sequencing: every state change and counter step waits for enabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
        end else if (enabled) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr   <= base_addr;
                        r_rem   <= expected_elements;
                        r_state <= (expected_elements == '0) ? DONE : ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (w_hs) begin
                        r_idx   <= '0;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    r_rem <= r_rem - ADDR_WIDTH'(1);
                    if (w_last_write) begin
                        r_state <= DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= w_continue ? WRITE : ACCEPT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_we   = w_writing;
    assign mem_addr = w_writing ? r_ptr : '0;
    assign mem_data = w_writing ? w_elem : '0;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE) && enabled;

endmodule

// File: tb/tb_full_vector_writer.sv
// tb/tb_full_vector_writer.sv - self-checking bench for full_vector_writer (table, directed and random jobs)
module tb_full_vector_writer;

    localparam int EW = 24;
    localparam int AW = 17;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enabled = 1'b0;
    logic          start = 1'b0;
    logic          vector_valid = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] expected_elements = '0;
    logic [EW-1:0] vector_in [0:D-1];
    logic          vector_ready;
    logic [AW-1:0] mem_addr;
    logic [EW-1:0] mem_data;
    logic          mem_we;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    full_vector_writer #(
        .ELEMENT_WIDTH    (EW),
        .ADDR_WIDTH       (AW),
        .VECTOR_DIMENSION (D)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enabled           (enabled),
        .start             (start),
        .base_addr         (base_addr),
        .expected_elements (expected_elements),
        .vector_in         (vector_in),
        .vector_valid      (vector_valid),
        .vector_ready      (vector_ready),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .mem_we            (mem_we),
        .busy              (busy),
        .done              (done)
    );

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    int wa[$];
    int wd[$];
    int wc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int stall_viol = 0;

    logic [EW-1:0] vecs [0:15][0:D-1];

    typedef struct {
        int base;
        int expn;
        int nvec;
        int first;
        int exp_last_addr;
        int exp_last_data;
    } vec_t;

    vec_t tbl [6];

    always @(posedge clk) cycle_no <= cycle_no + 1;

    // Write / done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_data));
            wc.push_back(cycle_no);
            if (!enabled) stall_viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cycle_no;
        end
        if (start && !busy) start_cyc = cycle_no;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wc.delete();
        done_cnt   = 0;
        stall_viol = 0;
    endtask

    task automatic fill_seq(input int nvec, input int first);
        for (int v = 0; v < nvec; v++)
            for (int e = 0; e < D; e++)
                vecs[v][e] = EW'(first + v * D + e);
    endtask

    // Drives one job to its done pulse; vectors come from vecs[0..nvec-1]
    task automatic run_job(input int base, input int expn, input int nvec, input int vpct,
                           input int epct, input int stall_at, input int stall_len, input bit spurious);
        int vi;
        int cyc;
        int stalled;
        bit fin;
        bit hs;
        bit prev_ok;
        vi = 0; cyc = 0; stalled = 0; fin = 0; prev_ok = 0;
        clear_mon();
        @(posedge clk); #1;
        enabled = 1'b1;
        start = 1'b1;
        base_addr = AW'(base);
        expected_elements = AW'(expn);
        vector_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            if (stall_at >= 0 && wa.size() >= stall_at && stalled < stall_len) begin
                enabled = 1'b0;
                stalled++;
            end else begin
                enabled = ($urandom_range(99) < epct);
            end
            if (!vector_valid && vi < nvec && $urandom_range(99) < vpct) vector_valid = 1'b1;
            if (vector_valid) for (int e = 0; e < D; e++) vector_in[e] = vecs[vi][e];
            if (spurious && prev_ok && $urandom_range(9) == 0) begin
                start = 1'b1;
                base_addr = AW'($urandom);
                expected_elements = AW'($urandom);
            end
            @(negedge clk);
            hs = vector_valid && vector_ready;
            if (done) fin = 1'b1;
            prev_ok = busy && !done;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) begin
                vi++;
                vector_valid = 1'b0;
            end
            cyc++;
        end
        check("job_done_seen", 64'(fin), 64'd1);
        vector_valid = 1'b0;
        enabled = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: write k goes to (base+k) mod 2**AW and carries flattened element k
    task automatic check_model(input string name, input int base, input int expn);
        int bad;
        int n;
        bad = 0;
        check({name, "_count"}, 64'(wa.size()), 64'(expn));
        n = (wa.size() < expn) ? wa.size() : expn;
        for (int k = 0; k < n; k++) begin
            if (wa[k] != (base + k) % (1 << AW) || wd[k] != int'(vecs[k / D][k % D])) bad++;
        end
        check({name, "_content_bad"}, 64'(bad), 64'd0);
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, "_we_while_stalled"}, 64'(stall_viol), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int span;
        int cyc;
        for (int e = 0; e < D; e++) vector_in[e] = '0;

        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(vector_ready), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        enabled = 1'b1;

        // Table-driven jobs: continuous valid, no stalls
        tbl[0] = '{base: 'h00100, expn: 6, nvec: 2, first: 1,         exp_last_addr: 'h00105, exp_last_data: 6};
        tbl[1] = '{base: 'h00200, expn: 4, nvec: 2, first: 7,         exp_last_addr: 'h00203, exp_last_data: 10};
        tbl[2] = '{base: 'h1FFFE, expn: 3, nvec: 1, first: 'h30,      exp_last_addr: 'h00000, exp_last_data: 'h32};
        tbl[3] = '{base: 'h00050, expn: 1, nvec: 1, first: 'hABCDE,   exp_last_addr: 'h00050, exp_last_data: 'hABCDE};
        tbl[4] = '{base: 'h1FFFF, expn: 5, nvec: 2, first: 'hFFFFF0,  exp_last_addr: 'h00003, exp_last_data: 'hFFFFF4};
        tbl[5] = '{base: 'h00123, expn: 0, nvec: 0, first: 0,         exp_last_addr: 0,       exp_last_data: 0};
        for (int t = 0; t < 6; t++) begin
            fill_seq(tbl[t].nvec, tbl[t].first);
            run_job(tbl[t].base, tbl[t].expn, tbl[t].nvec, 100, 100, -1, 0, 1'b0);
            check_model("tbl", tbl[t].base, tbl[t].expn);
            if (tbl[t].expn > 0 && wa.size() > 0) begin
                check("tbl_last_addr", 64'(wa[wa.size()-1]), 64'(tbl[t].exp_last_addr));
                check("tbl_last_data", 64'(wd[wd.size()-1]), 64'(tbl[t].exp_last_data));
                check("tbl_done_after_last", 64'(done_cyc), 64'(wc[wc.size()-1] + 1));
            end else begin
                check("tbl_done_after_start", 64'(done_cyc), 64'(start_cyc + 1));
            end
        end

        // Stall for 5 cycles after the 2nd write
        fill_seq(2, 1);
        run_job('h00400, 6, 2, 100, 100, 2, 5, 1'b0);
        check_model("stall", 'h00400, 6);
        if (wc.size() >= 3) check("stall_gap", 64'(wc[2] - wc[1]), 64'd6);

        // Asynchronous reset after the 2nd write abandons the job
        clear_mon();
        fill_seq(2, 1);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'('h300); expected_elements = AW'(6);
        vector_valid = 1'b1;
        for (int e = 0; e < D; e++) vector_in[e] = vecs[0][e];
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (wa.size() < 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rstmid_writes_before", 64'(wa.size()), 64'd2);
        reset_n = 1'b0;
        #1;
        check("rstmid_mem_we", 64'(mem_we), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_addr", 64'(mem_addr), 64'd0);
        check("rstmid_data", 64'(mem_data), 64'd0);
        check("rstmid_ready", 64'(vector_ready), 64'd0);
        vector_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_no_more_writes", 64'(wa.size()), 64'd2);
        run_job('h00077, 0, 0, 100, 100, -1, 0, 1'b0);
        check_model("rst_zero", 'h00077, 0);
        check("rst_zero_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));

        // Throughput with valid held high
        fill_seq(3, 'h500);
        run_job('h00010, 9, 3, 100, 100, -1, 0, 1'b0);
        check_model("thru", 'h00010, 9);
        span = (wc.size() > 0) ? (wc[wc.size()-1] - wc[0] + 1) : 0;
`ifdef VECTOR_WRITER_SKID_EN
        check("thru_span", 64'(span), 64'd9);
`else
        check("thru_span", 64'(span), 64'd11);
`endif

        // Random jobs: gaps on valid, random stalls, ignored start pulses
        for (int j = 0; j < 24; j++) begin
            int b;
            int n;
            int nv;
            b  = ($urandom_range(1) == 1) ? ((1 << AW) - 1 - int'($urandom_range(15)))
                                          : int'($urandom & 32'h1FFFF);
            n  = int'($urandom_range(20));
            nv = (n + D - 1) / D + int'($urandom_range(1));
            for (int v = 0; v < nv; v++)
                for (int e = 0; e < D; e++)
                    vecs[v][e] = EW'($urandom);
            run_job(b, n, nv, int'($urandom_range(40, 100)), int'($urandom_range(60, 100)), -1, 0, 1'b1);
            check_model("rand", b, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
